// File: rtl/gpsclock_tbx_pkg.sv
// Shared definitions for the PPS generator / timestamp test block: register map,
// STATUS layout and the snapshot record captured on each local PPS edge.
package gpsclock_tbx_pkg;

    typedef logic [31:0] word_t;

    localparam logic [1:0] REG_MAXCOUNT = 2'd0;
    localparam logic [1:0] REG_JUMP     = 2'd1;
    localparam logic [1:0] REG_DRIFT    = 2'd2;
    localparam logic [1:0] REG_WIDTH    = 2'd3;

    localparam logic [4:0] ADDR_STATUS  = 5'h10;
    localparam logic [4:0] ADDR_LCL     = 5'h11;
    localparam logic [4:0] ADDR_ERR_HI  = 5'h12;
    localparam logic [4:0] ADDR_ERR_LO  = 5'h13;
    localparam logic [4:0] ADDR_CNT_HI  = 5'h14;
    localparam logic [4:0] ADDR_CNT_LO  = 5'h15;
    localparam logic [4:0] ADDR_STEP_HI = 5'h16;
    localparam logic [4:0] ADDR_STEP_LO = 5'h17;

    localparam int STATUS_OVF_BIT = 8;
    localparam int STATUS_FILL_W  = 5;

    typedef struct packed {
        logic [31:0] lcl;
        logic [63:0] err;
        logic [63:0] count;
        logic [63:0] step;
    } snap_t;

endpackage

// File: rtl/gpsclock_tbx_chan.sv
// One PPS generator channel: fractional drift accumulator, wrapping tick counter
// with one-shot jump, and a retriggerable output pulse of programmable width.
module gpsclock_tbx_chan
    import gpsclock_tbx_pkg::*;
#(
    parameter logic [31:0] RESET_MAXCOUNT = 32'd81_250_000
) (
    input  logic  i_clk,
    input  logic  i_reset_n,
    input  logic  i_wr_maxcount,
    input  logic  i_wr_jump,
    input  logic  i_wr_drift,
    input  logic  i_wr_width,
    input  word_t i_wdata,
    output word_t o_maxcount,
    output word_t o_drift,
    output word_t o_width,
    output logic  o_pps
);

    word_t maxcount_q, maxcount_d;
    word_t jump_q, jump_d;
    word_t drift_q, drift_d;
    word_t width_q, width_d;
    word_t ctr_q, ctr_d;
    word_t frac_q, frac_d;
    word_t wcnt_q, wcnt_d;
    logic  pps_q, pps_d;

    logic [32:0] frac_sum;
    logic [1:0]  inc;
    logic [33:0] sum;
    logic [33:0] diff;
    logic        enabled;
    logic        wrap;

    always_comb begin
        enabled  = (maxcount_q != 32'd0);
        frac_sum = {1'b0, frac_q} + {1'b0, drift_q};
        // With a negative drift the unsigned carry-out means "no borrow".
        if (!drift_q[31]) inc = frac_sum[32] ? 2'd2 : 2'd1;
        else              inc = frac_sum[32] ? 2'd1 : 2'd0;
        sum  = {2'b00, ctr_q} + {32'd0, inc} + {2'b00, jump_q};
        diff = sum - {2'b00, maxcount_q};
        wrap = enabled && (sum >= {2'b00, maxcount_q});

        maxcount_d = maxcount_q;
        drift_d    = drift_q;
        width_d    = width_q;
        jump_d     = 32'd0;
        frac_d     = frac_sum[31:0];
        ctr_d      = wrap ? diff[31:0] : sum[31:0];
        pps_d      = pps_q;
        wcnt_d     = wcnt_q;

        if (wrap) begin
            pps_d  = 1'b1;
            wcnt_d = width_q;
        end else if (pps_q) begin
            if (wcnt_q == 32'd0) pps_d  = 1'b0;
            else                 wcnt_d = wcnt_q - 32'd1;
        end

        if (!enabled) begin
            ctr_d  = 32'd0;
            frac_d = 32'd0;
            pps_d  = 1'b0;
            wcnt_d = 32'd0;
        end

        if (i_wr_jump)  jump_d  = i_wdata;
        if (i_wr_drift) drift_d = i_wdata;
        if (i_wr_width) width_d = i_wdata;
        if (i_wr_maxcount) begin
            maxcount_d = i_wdata;
            ctr_d      = 32'd0;
            frac_d     = 32'd0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            maxcount_q <= RESET_MAXCOUNT;
            jump_q     <= 32'd0;
            drift_q    <= 32'd0;
            width_q    <= 32'd0;
            ctr_q      <= 32'd0;
            frac_q     <= 32'd0;
            wcnt_q     <= 32'd0;
            pps_q      <= 1'b0;
        end else begin
            maxcount_q <= maxcount_d;
            jump_q     <= jump_d;
            drift_q    <= drift_d;
            width_q    <= width_d;
            ctr_q      <= ctr_d;
            frac_q     <= frac_d;
            wcnt_q     <= wcnt_d;
            pps_q      <= pps_d;
        end
    end

    assign o_maxcount = maxcount_q;
    assign o_drift    = drift_q;
    assign o_width    = width_q;
    assign o_pps      = pps_q & enabled;

endmodule

// File: rtl/gpsclock_tbx.sv
// PPS generator bank with a Wishbone register file and a snapshot FIFO that
// timestamps the clock-under-test status on each rising edge of the local PPS.
module gpsclock_tbx
    import gpsclock_tbx_pkg::*;
#(
    parameter int          NCH                = 2,
    parameter int          DEPTH              = 4,
    parameter int unsigned CLOCK_FREQUENCY_HZ = 81_250_000
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_wb_cyc_stb,
    input  logic            i_wb_we,
    input  logic [4:0]      i_wb_addr,
    input  logic [31:0]     i_wb_data,
    output logic            o_wb_ack,
    output logic            o_wb_stall,
    output logic [31:0]     o_wb_data,
    input  logic            i_lcl_pps,
    input  logic [63:0]     i_err,
    input  logic [63:0]     i_count,
    input  logic [63:0]     i_step,
    output logic [NCH-1:0]  o_pps
);

    localparam int AW = $clog2(DEPTH);

    logic req_wr, req_rd;
    assign req_wr = i_wb_cyc_stb & i_wb_we;
    assign req_rd = i_wb_cyc_stb & ~i_wb_we;

    word_t ch_max   [4];
    word_t ch_drift [4];
    word_t ch_width [4];

    for (genvar c = 0; c < 4; c++) begin : g_chan
        if (c < NCH) begin : g_on
            logic sel;
            assign sel = req_wr && !i_wb_addr[4] && (i_wb_addr[3:2] == 2'(c));
            gpsclock_tbx_chan #(
                .RESET_MAXCOUNT (32'(CLOCK_FREQUENCY_HZ))
            ) u_chan (
                .i_clk         (i_clk),
                .i_reset_n     (i_reset_n),
                .i_wr_maxcount (sel && (i_wb_addr[1:0] == REG_MAXCOUNT)),
                .i_wr_jump     (sel && (i_wb_addr[1:0] == REG_JUMP)),
                .i_wr_drift    (sel && (i_wb_addr[1:0] == REG_DRIFT)),
                .i_wr_width    (sel && (i_wb_addr[1:0] == REG_WIDTH)),
                .i_wdata       (i_wb_data),
                .o_maxcount    (ch_max[c]),
                .o_drift       (ch_drift[c]),
                .o_width       (ch_width[c]),
                .o_pps         (o_pps[c])
            );
        end else begin : g_off
            assign ch_max[c]   = 32'd0;
            assign ch_drift[c] = 32'd0;
            assign ch_width[c] = 32'd0;
        end
    end

    logic        ack_q, ack_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] lcl_q, lcl_d;
    logic        edge_q, edge_d;
    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    logic        ovf_q, ovf_d;
    snap_t       mem_q [DEPTH];

    logic [AW:0] used;
    logic        empty, full, push, pop, do_push;
    snap_t       head, snap_in;
    logic [31:0] rd_data;

    always_comb begin
        used    = wptr_q - rptr_q;
        empty   = (used == '0);
        full    = used[AW];
        push    = i_lcl_pps & ~edge_q;
        pop     = req_rd && (i_wb_addr == ADDR_STEP_LO) && !empty;
        // A full FIFO still accepts a push when the same edge frees a slot.
        do_push = push && (!full || pop);
        snap_in = '{lcl: lcl_q, err: i_err, count: i_count, step: i_step};
        head    = empty ? '0 : mem_q[rptr_q[AW-1:0]];

        rd_data = 32'd0;
        if (!i_wb_addr[4]) begin
            case (i_wb_addr[1:0])
                REG_MAXCOUNT: rd_data = ch_max[i_wb_addr[3:2]];
                REG_DRIFT:    rd_data = ch_drift[i_wb_addr[3:2]];
                REG_WIDTH:    rd_data = ch_width[i_wb_addr[3:2]];
                default:      rd_data = 32'd0;
            endcase
        end else begin
            case (i_wb_addr)
                ADDR_STATUS: begin
                    rd_data[STATUS_OVF_BIT]        = ovf_q;
                    rd_data[STATUS_FILL_W-1:0]     = STATUS_FILL_W'(used);
                end
                ADDR_LCL:     rd_data = head.lcl;
                ADDR_ERR_HI:  rd_data = head.err[63:32];
                ADDR_ERR_LO:  rd_data = head.err[31:0];
                ADDR_CNT_HI:  rd_data = head.count[63:32];
                ADDR_CNT_LO:  rd_data = head.count[31:0];
                ADDR_STEP_HI: rd_data = head.step[63:32];
                ADDR_STEP_LO: rd_data = head.step[31:0];
                default:      rd_data = 32'd0;
            endcase
        end

        ack_d   = i_wb_cyc_stb;
        rdata_d = req_rd ? rd_data : 32'd0;
        lcl_d   = lcl_q + 32'd1;
        edge_d  = i_lcl_pps;
        wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
        ovf_d   = ovf_q;
        if (req_wr && (i_wb_addr == ADDR_STATUS) && i_wb_data[STATUS_OVF_BIT]) ovf_d = 1'b0;
        if (push && !do_push) ovf_d = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ack_q   <= 1'b0;
            rdata_q <= 32'd0;
            lcl_q   <= 32'd0;
            edge_q  <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            lcl_q   <= lcl_d;
            edge_q  <= edge_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= snap_in;
    end

    assign o_wb_ack   = ack_q;
    assign o_wb_stall = 1'b0;
    assign o_wb_data  = rdata_q;

endmodule

// File: tb/tb_gpsclock_tbx.sv
// Directed bench for gpsclock_tbx: register map, PPS timing, drift, jump,
// snapshot FIFO and asynchronous reset behaviour.
`timescale 1ns/1ps
module tb_gpsclock_tbx;

    localparam int NCH   = 2;
    localparam int DEPTH = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           cyc_stb, we;
    logic [4:0]     addr;
    logic [31:0]    wdata;
    logic           ack, stall;
    logic [31:0]    rdata;
    logic           lcl_pps;
    logic [63:0]    err, count, step;
    logic [NCH-1:0] pps;

    always #5 clk = ~clk;

    gpsclock_tbx #(.NCH(NCH), .DEPTH(DEPTH), .CLOCK_FREQUENCY_HZ(81_250_000)) dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_wb_cyc_stb (cyc_stb),
        .i_wb_we      (we),
        .i_wb_addr    (addr),
        .i_wb_data    (wdata),
        .o_wb_ack     (ack),
        .o_wb_stall   (stall),
        .o_wb_data    (rdata),
        .i_lcl_pps    (lcl_pps),
        .i_err        (err),
        .i_count      (count),
        .i_step       (step),
        .o_pps        (pps)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Cycle counter, local-counter model and per-channel pulse monitor.
    int             cyc = 0;
    logic [31:0]    mlcl;
    int             n_rise [NCH];
    int             n_fall [NCH];
    int             run    [NCH];
    int             last_w [NCH];
    int             rise_t [NCH][64];
    logic [NCH-1:0] pps_prev = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) mlcl <= 32'd0;
        else        mlcl <= mlcl + 32'd1;

    always @(negedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (pps[c] && !pps_prev[c]) begin
                rise_t[c][n_rise[c][5:0]] = cyc;
                n_rise[c]++;
            end
            if (pps[c]) run[c]++;
            else if (pps_prev[c]) begin
                last_w[c] = run[c];
                n_fall[c]++;
                run[c] = 0;
            end
        end
        pps_prev = pps;
    end

    function automatic int ivl(input int ch, input int k);
        int a;
        int b;
        a = k;
        b = k - 1;
        return rise_t[ch][a[5:0]] - rise_t[ch][b[5:0]];
    endfunction

    task automatic wait_ev(input string tag, input int ch, input bit falls, input int target, input int budget);
        int k;
        k = 0;
        while (((falls ? n_fall[ch] : n_rise[ch]) < target) && (k < budget)) begin
            @(posedge clk); #1;
            k++;
        end
        chk(tag, 32'((falls ? n_fall[ch] : n_rise[ch]) >= target), 32'd1);
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        cyc_stb = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(posedge clk); #1;
        cyc_stb = 1'b0; we = 1'b0;
        chk("wr_ack", 32'(ack), 32'd1);
    endtask

    task automatic wb_read(input logic [4:0] a, output logic [31:0] d);
        cyc_stb = 1'b1; we = 1'b0; addr = a;
        @(posedge clk); #1;
        cyc_stb = 1'b0;
        chk("rd_ack", 32'(ack), 32'd1);
        d = rdata;
    endtask

    logic [31:0] exp_lcl [10];

    function automatic logic [31:0] tagw(input logic [15:0] hi, input int k);
        return {hi, 16'(k)};
    endfunction

    function automatic logic [31:0] snap_word(input int k, input int i);
        case (i)
            0:       return exp_lcl[k];
            1:       return tagw(16'hEEEE, k);
            2:       return tagw(16'h1111, k);
            3:       return tagw(16'hC0C0, k);
            4:       return tagw(16'h2222, k);
            5:       return tagw(16'h5E5E, k);
            default: return tagw(16'h3333, k);
        endcase
    endfunction

    task automatic set_snap_inputs(input int k);
        err   = {tagw(16'hEEEE, k), tagw(16'h1111, k)};
        count = {tagw(16'hC0C0, k), tagw(16'h2222, k)};
        step  = {tagw(16'h5E5E, k), tagw(16'h3333, k)};
        exp_lcl[k] = mlcl;
    endtask

    task automatic push_snap(input int k);
        set_snap_inputs(k);
        lcl_pps = 1'b1;
        @(posedge clk); #1;
        lcl_pps = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] d;
        int r0, n1, f0, hi, k;

        rst_n = 1'b0; cyc_stb = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        lcl_pps = 1'b0; err = '0; count = '0; step = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pps", 32'(pps), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_data", rdata, 32'd0);
        chk("stall", 32'(stall), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        wb_read(5'h00, d); chk("rst_max0", d, 32'd81_250_000);
        wb_read(5'h04, d); chk("rst_max1", d, 32'd81_250_000);
        wb_read(5'h02, d); chk("rst_drift0", d, 32'd0);
        wb_read(5'h07, d); chk("rst_width1", d, 32'd0);
        wb_read(5'h10, d); chk("rst_status", d, 32'd0);
        @(posedge clk); #1;
        chk("ack_one_cycle", 32'(ack), 32'd0);

        // Basic period and single-cycle pulse.
        wb_write(5'h00, 32'd10);
        wait_ev("p34_wait", 0, 1'b0, 3, 100);
        chk("p34_period", 32'(ivl(0, n_rise[0] - 1)), 32'd10);
        chk("p34_width", 32'(last_w[0]), 32'd1);
        chk("p34_ch1_idle", 32'(n_rise[1]), 32'd0);

        // One-shot jump on channel 1.
        wb_write(5'h04, 32'd10);
        n1 = n_rise[1];
        wait_ev("p36_sync", 1, 1'b0, n1 + 1, 40);
        wb_write(5'h05, 32'd3);
        wait_ev("p36_wait", 1, 1'b0, n1 + 3, 60);
        chk("p36_early", 32'(ivl(1, n1 + 1)), 32'd7);
        chk("p36_after", 32'(ivl(1, n1 + 2)), 32'd10);
        chk("p36_ch0", 32'(ivl(0, n_rise[0] - 1)), 32'd10);
        wb_read(5'h05, d); chk("jump_reads0", d, 32'd0);

        // Pulse width and retrigger.
        wb_write(5'h03, 32'd4);
        f0 = n_fall[0];
        wait_ev("p38_wfall", 0, 1'b1, f0 + 2, 60);
        chk("p38_width", 32'(last_w[0]), 32'd5);
        wb_write(5'h03, 32'd12);
        repeat (25) @(posedge clk);
        #1;
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            hi += int'(pps[0]);
        end
        chk("wrap_restart", 32'(hi), 32'd20);

        // MAXCOUNT = 0 disables the channel.
        wb_write(5'h00, 32'd0);
        wb_write(5'h03, 32'd0);
        hi = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            hi += int'(pps[0]);
        end
        chk("disabled_low", 32'(hi), 32'd0);
        wb_read(5'h00, d); chk("disabled_max", d, 32'd0);

        // Positive drift: 125 ticks per 100 cycles.
        wb_write(5'h02, 32'h4000_0000);
        wb_write(5'h00, 32'd100);
        repeat (10) @(posedge clk);
        #1;
        r0 = n_rise[0];
        repeat (400) @(posedge clk);
        #1;
        chk("p35_count", 32'(n_rise[0] - r0), 32'd5);
        chk("p35_period", 32'(ivl(0, n_rise[0] - 1)), 32'd80);

        // Negative drift: 30 ticks per 40 cycles.
        wb_write(5'h02, 32'hC000_0000);
        wb_write(5'h00, 32'd30);
        r0 = n_rise[0];
        wait_ev("negdrift_wait", 0, 1'b0, r0 + 3, 200);
        chk("negdrift_period", 32'(ivl(0, n_rise[0] - 1)), 32'd40);
        wb_read(5'h02, d); chk("drift_rb", d, 32'hC000_0000);

        // Nonexistent channel and unmapped addresses.
        wb_write(5'h08, 32'h1234);
        wb_read(5'h08, d); chk("ch2_max", d, 32'd0);
        wb_read(5'h0A, d); chk("ch2_drift", d, 32'd0);
        wb_read(5'h18, d); chk("unmapped", d, 32'd0);

        // Snapshot FIFO overflow and head reads.
        for (int i = 0; i < 5; i++) push_snap(i);
        wb_read(5'h10, d); chk("p37_status", d, 32'h0000_0104);
        for (int i = 0; i < 7; i++) begin
            wb_read(5'(32'h11 + i), d);
            chk($sformatf("p37_rd%0d", i), d, snap_word(0, i));
        end
        wb_read(5'h10, d); chk("p37_status_pop", d, 32'h0000_0103);
        for (int i = 1; i < 4; i++) begin
            wb_read(5'h17, d);
            chk($sformatf("drain%0d", i), d, snap_word(i, 6));
        end
        wb_read(5'h10, d); chk("drained_status", d, 32'h0000_0100);
        wb_read(5'h17, d); chk("p38_empty_rd", d, 32'd0);
        wb_read(5'h10, d); chk("p38_empty_fill", d, 32'h0000_0100);
        wb_write(5'h10, 32'h0000_0100);
        wb_read(5'h10, d); chk("ovf_clear", d, 32'd0);

        // Push and pop on the same edge while full.
        for (int i = 5; i < 9; i++) push_snap(i);
        k = 9;
        set_snap_inputs(k);
        lcl_pps = 1'b1;
        wb_read(5'h17, d); chk("full_pushpop_data", d, snap_word(5, 6));
        lcl_pps = 1'b0;
        wb_read(5'h10, d); chk("full_pushpop_status", d, 32'h0000_0004);
        wb_read(5'h11, d); chk("full_pushpop_head", d, snap_word(6, 0));

        // Asynchronous reset in the middle of a pulse with a request pending.
        wb_write(5'h02, 32'd0);
        wb_write(5'h03, 32'd4);
        wb_write(5'h00, 32'd10);
        k = 0;
        while (!pps[0] && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        chk("p39_in_pulse", 32'(pps[0]), 32'd1);
        cyc_stb = 1'b1; we = 1'b0; addr = 5'h00;
        rst_n = 1'b0;
        #1;
        chk("p39_pps", 32'(pps), 32'd0);
        chk("p39_ack", 32'(ack), 32'd0);
        @(posedge clk); #1;
        chk("p39_ack_hold", 32'(ack), 32'd0);
        cyc_stb = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("p39_noack", 32'(ack), 32'd0);
        chk("p39_pps_after", 32'(pps), 32'd0);
        wb_read(5'h00, d); chk("p39_max0", d, 32'd81_250_000);
        wb_read(5'h03, d); chk("p39_width0", d, 32'd0);
        wb_read(5'h02, d); chk("p39_drift0", d, 32'd0);
        wb_read(5'h04, d); chk("p39_max1", d, 32'd81_250_000);
        wb_read(5'h10, d); chk("p39_status", d, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
